// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Brief    : Time-multiplexed hex driver for a common-anode 7-segment bank with
//            frame-synchronous update, leading-zero blanking and anode dead time.
//            Optional decimal points when SEVEN_SEG_SCAN_DP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    input  logic                blank_en,
    output logic [6:0]          segments,
    output logic [DIGITS-1:0]   anodes,
    output logic [IDX_W-1:0]    digit_idx
`ifdef SEVEN_SEG_SCAN_DP_EN
    ,
    input  logic [DIGITS-1:0]   dp,
    output logic                dp_n
`endif
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       c_seg_off  = 7'b111_1111;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_disp;
    logic                r_pend;

    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_an;
    logic                w_upper_zero;
    logic                w_blank;
    logic                w_slot_end;
    logic                w_frame_end;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    f_decode = 7'b000_0001;
            4'h1:    f_decode = 7'b100_1111;
            4'h2:    f_decode = 7'b001_0010;
            4'h3:    f_decode = 7'b000_0110;
            4'h4:    f_decode = 7'b100_1100;
            4'h5:    f_decode = 7'b010_0100;
            4'h6:    f_decode = 7'b010_0000;
            4'h7:    f_decode = 7'b000_1111;
            4'h8:    f_decode = 7'b000_0000;
            4'h9:    f_decode = 7'b000_1100;
            4'hA:    f_decode = 7'b000_1000;
            4'hB:    f_decode = 7'b110_0000;
            4'hC:    f_decode = 7'b011_0001;
            4'hD:    f_decode = 7'b100_0010;
            4'hE:    f_decode = 7'b011_0000;
            default: f_decode = 7'b011_1000;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == c_cnt_last);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);
    assign digit_idx   = r_idx;

    // Select the active nibble and check whether it and everything above is zero
    always_comb begin
        w_nib        = 4'h0;
        w_an         = '1;
        w_upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_nib   = r_disp[4*k +: 4];
                w_an[k] = 1'b0;
            end
            if ((IDX_W'(k) >= r_idx) && (r_disp[4*k +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_blank = blank_en && (r_idx != '0) && w_upper_zero;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_pend   <= 1'b0;
            segments <= c_seg_off;
            anodes   <= '1;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // A load on the frame-end edge re-arms pending after the transfer
            if (w_frame_end && r_pend) begin
                r_disp <= r_shadow;
                r_pend <= 1'b0;
            end
            if (load) begin
                r_shadow <= value;
                r_pend   <= 1'b1;
            end

            if (r_cnt == '0) begin
                anodes   <= '1;
                segments <= c_seg_off;
            end else begin
                anodes   <= w_an;
                segments <= w_blank ? c_seg_off : f_decode(w_nib);
            end
        end
    end

`ifdef SEVEN_SEG_SCAN_DP_EN
    logic [DIGITS-1:0] r_dp_shadow;
    logic [DIGITS-1:0] r_dp_disp;
    logic              w_dp_bit;

    always_comb begin
        w_dp_bit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_dp_bit = r_dp_disp[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_shadow <= '0;
            r_dp_disp   <= '0;
            dp_n        <= 1'b1;
        end else begin
            if (w_frame_end && r_pend) begin
                r_dp_disp <= r_dp_shadow;
            end
            if (load) begin
                r_dp_shadow <= dp;
            end
            dp_n <= (r_cnt == '0) || w_blank || !w_dp_bit;
        end
    end
`else
    // Decimal-point storage and output are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan
// Brief    : Self-checking bench for seven_seg_scan (DIGITS=4, REFRESH_DIV=4)
//            against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int FRAME       = DIGITS * REFRESH_DIV;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        blank_en = 1'b0;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic [1:0]  digit_idx;

    int          n_vec = 0;
    int          n_err = 0;

    // Reference state: position in the scan since reset plus load bookkeeping
    int          m_pos = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp = '0;
    bit          m_pend = 1'b0;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic [1:0]  e_idx;
    bit          g_be = 1'b0;

    seven_seg_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .blank_en  (blank_en),
        .segments  (segments),
        .anodes    (anodes),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t pos=%0d: got %h expected %h", tag, $time, m_pos, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ld, input logic [15:0] v, input bit be);
        int cnt;
        int idx;
        if (r) begin
            m_pos    = 0;
            m_shadow = '0;
            m_disp   = '0;
            m_pend   = 1'b0;
            e_seg    = 7'h7F;
            e_an     = 4'hF;
        end else begin
            cnt = m_pos % REFRESH_DIV;
            idx = (m_pos / REFRESH_DIV) % DIGITS;
            if (cnt == 0) begin
                e_seg = 7'h7F;
                e_an  = 4'hF;
            end else begin
                e_an = 4'hF & ~(4'h1 << idx);
                if (be && idx != 0 && (m_disp >> (4 * idx)) == 16'h0)
                    e_seg = 7'h7F;
                else
                    e_seg = SEG_TAB[(m_disp >> (4 * idx)) & 16'hF];
            end
            if ((m_pos % FRAME) == FRAME - 1 && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_shadow = v;
                m_pend   = 1'b1;
            end
            m_pos++;
        end
        e_idx = 2'((m_pos / REFRESH_DIV) % DIGITS);
    endtask

    task automatic step(input bit r, input bit ld, input logic [15:0] v);
        @(negedge clk);
        rst      = r;
        load     = ld;
        value    = v;
        blank_en = g_be;
        @(posedge clk);
        #1;
        model_edge(r, ld, v, g_be);
        chk("segments", 32'(segments), 32'(e_seg));
        chk("anodes", 32'(anodes), 32'(e_an));
        chk("digit_idx", 32'(digit_idx), 32'(e_idx));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    // Advance until the next edge sees the requested frame phase
    task automatic align(input int phase);
        for (int i = 0; i < FRAME && (m_pos % FRAME) != phase; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0);
        idle(4);
        step(1'b0, 1'b1, 16'h12AF);
        idle(3 * FRAME);

        g_be = 1'b1;
        align(2);
        step(1'b0, 1'b1, 16'h0000);
        idle(3);
        step(1'b0, 1'b1, 16'h0045);
        idle(3 * FRAME);

        step(1'b0, 1'b1, 16'h0000);
        idle(3 * FRAME);
        step(1'b0, 1'b1, 16'h0100);
        idle(3 * FRAME);

        align(FRAME - 1);
        step(1'b0, 1'b1, 16'hBEEF);
        idle(3 * FRAME);

        step(1'b0, 1'b1, 16'h3C07);
        align(11);
        step(1'b1, 1'b0, 16'h0);
        idle(2 * FRAME);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(63) == 0) g_be = ~g_be;
            step(($urandom_range(299) == 0), ($urandom_range(7) == 0), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
